// File: rtl/digit_scan_ctrl.sv
// Multiplexed 4-digit BCD scan driver with a frame-synchronous double-dabble converter; outputs are combinational from state.
// Latency: value sampled at frame_tick N appears from the frame after frame_tick N+1; no backpressure, free-running scan.
module digit_scan_ctrl #(
    parameter int TICK_DIV  = 50000,
    parameter int BLANK_CYC = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] value,
    input  logic        lzb,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic [3:0]  dig_en,
    output logic        frame_tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_V   = CNT_W'(BLANK_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    logic [CNT_W-1:0] r_slot_cnt;
    logic [1:0]       r_dig_idx;
    logic [15:0]      r_disp;
    logic [15:0]      r_shadow;
    logic [15:0]      r_bcd;
    logic [13:0]      r_bin;
    logic [3:0]       r_shift_cnt;
    conv_state_t      r_state;
    conv_state_t      w_state_nxt;

    logic             w_slot_wrap;
    logic             w_frame_tick;
    logic             w_blank;
    logic [13:0]      w_value_sat;
    logic [15:0]      w_bcd_adj;
    logic [3:0]       w_cur_digit;
    logic [3:0]       w_sup;

    assign w_slot_wrap  = (r_slot_cnt == SLOT_LAST);
    assign w_frame_tick = w_slot_wrap && (r_dig_idx == 2'd3);
    assign w_value_sat  = (value > 14'd9999) ? 14'd9999 : value;

    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign w_blank = 1'b0;
        end else begin : g_blank
            assign w_blank = (r_slot_cnt < BLANK_V);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_cnt <= '0;
            r_dig_idx  <= 2'd0;
        end else if (w_slot_wrap) begin
            r_slot_cnt <= '0;
            r_dig_idx  <= r_dig_idx + 2'd1;
        end else begin
            r_slot_cnt <= r_slot_cnt + CNT_W'(1);
        end
    end

    // Display loads the previous conversion result on the same edge a new capture starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp <= '0;
        end else if (w_frame_tick) begin
            r_disp <= r_shadow;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_frame_tick) w_state_nxt = SHIFT;
            SHIFT:   if (r_shift_cnt == 4'd13) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin       <= '0;
            r_bcd       <= '0;
            r_shift_cnt <= '0;
            r_shadow    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_frame_tick) begin
                        r_bin       <= w_value_sat;
                        r_bcd       <= '0;
                        r_shift_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_bcd       <= {w_bcd_adj[14:0], r_bin[13]};
                    r_bin       <= {r_bin[12:0], 1'b0};
                    r_shift_cnt <= r_shift_cnt + 4'd1;
                end
                DONE: begin
                    r_shadow <= r_bcd;
                end
                default: begin
                end
            endcase
        end
    end

    // Digit k is blanked when it and every higher digit are zero; the ones digit always shows.
    assign w_sup[0] = 1'b0;
    assign w_sup[1] = lzb && (r_disp[15:4]  == 12'd0);
    assign w_sup[2] = lzb && (r_disp[15:8]  == 8'd0);
    assign w_sup[3] = lzb && (r_disp[15:12] == 4'd0);

    assign w_cur_digit = r_disp[{r_dig_idx, 2'b00} +: 4];

    always_comb begin
        dig_en = 4'b0000;
        if (!reset && !w_blank) begin
            dig_en = (4'b0001 << r_dig_idx) & ~w_sup;
        end
    end

    assign {A, B, C, D} = reset ? 4'b0000 : w_cur_digit;
    assign frame_tick   = !reset && w_frame_tick;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: directed and random stimulus against a frame-level arithmetic model of the display.
module tb_digit_scan_ctrl;

    localparam int TD    = 20;
    localparam int BC    = 2;
    localparam int FRAME = 4 * TD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] value = '0;
    logic        lzb = 1'b0;
    logic        A, B, C, D;
    logic [3:0]  dig_en;
    logic        frame_tick;

    int n_vec = 0;
    int n_err = 0;

    int m_t      = 0;
    int m_disp   = 0;
    int m_shadow = 0;

    digit_scan_ctrl #(
        .TICK_DIV  (TD),
        .BLANK_CYC (BC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .lzb        (lzb),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .dig_en     (dig_en),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (t=%0d disp=%0d)", tag, obs, exp, m_t, m_disp);
        end
    endtask

    // One clock: drive inputs at negedge, compare outputs, then advance the model on the rising edge.
    task automatic step(input logic rst, input int val, input logic lz);
        int slot, d, e_en, e_dig, e_ft;
        bit sup;
        @(negedge clk);
        reset = rst;
        value = val[13:0];
        lzb   = lz;
        #1;
        if (rst) begin
            e_en = 0; e_dig = 0; e_ft = 0;
        end else begin
            slot  = m_t % TD;
            d     = m_t / TD;
            e_ft  = (m_t == FRAME - 1) ? 1 : 0;
            e_dig = (m_disp / pow10(d)) % 10;
            sup   = lz && (d > 0) && (m_disp < pow10(d));
            e_en  = (slot < BC || sup) ? 0 : (1 << d);
        end
        check("dig_en", int'(dig_en), e_en);
        check("abcd", int'({A, B, C, D}), e_dig);
        check("frame_tick", int'(frame_tick), e_ft);
        @(posedge clk);
        if (rst) begin
            m_t = 0; m_disp = 0; m_shadow = 0;
        end else begin
            if (m_t == FRAME - 1) begin
                m_disp   = m_shadow;
                m_shadow = sat(int'(val[13:0]));
            end
            m_t = (m_t + 1) % FRAME;
        end
    endtask

    initial begin
        logic lz_r;
        int   v;

        repeat (3) step(1'b1, 1234, 1'b0);

        repeat (4 * FRAME) step(1'b0, 1234, 1'b0);

        repeat (3 * FRAME) step(1'b0, 12000, 1'b0);

        repeat (3 * FRAME) step(1'b0, 7, 1'b1);
        repeat (3 * FRAME) step(1'b0, 0, 1'b1);

        // Intra-frame toggling; only the value held across the frame_tick edge may ever be shown.
        repeat (3 * FRAME) begin
            v = ((m_t == FRAME - 1) || (m_t % 3 != 0)) ? 1234 : 5678;
            step(1'b0, v, 1'b0);
        end

        repeat (2 * FRAME) step(1'b0, 4321, 1'b0);
        for (int i = 0; i < FRAME && m_t != 2 * TD + 10; i++) step(1'b0, 4321, 1'b0);
        step(1'b1, 4321, 1'b0);
        repeat (3 * FRAME) step(1'b0, 4321, 1'b1);

        for (int i = 0; i < FRAME && m_t != 5; i++) step(1'b0, 9087, 1'b0);
        step(1'b1, 9087, 1'b0);
        repeat (3 * FRAME) step(1'b0, 560, 1'b1);

        lz_r = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 99) == 0) lz_r = ~lz_r;
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 99));
            else v = int'($urandom_range(0, 16383));
            step($urandom_range(0, 299) == 0, v, lz_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
